pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Instruction-fetch stage of the 32-bit MIPS processor. Holds the program counter, drives the word address into the instruction memory, and latches the returned instruction into the IF/ID pipeline register. Handles sequential fetch, branch/jump redirect with flush, decode stalls and a halt word that freezes fetch.

Parameters:
ADDR_BITS, 8, instruction memory depth is 2**ADDR_BITS words; the PC is a word address and upper bits are always 0
RESET_ADDR, 0, word address loaded into the PC on reset
HALT_INSTR, 32'hFFFFFFFF, instruction word that stops fetch

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
branch_taken  input  1  EX stage: taken branch this cycle
branch_target  input  32  EX stage: absolute word address of the branch target
jump  input  1  ID stage: j/jal decoded
jump_index  input  26  ID stage: instr[25:0], a word index
instruction  input  32  combinational read data from instruction memory
ReadAddress  output  32  word address to instruction memory; equals the PC
ifid_instruction  output  32  IF/ID instruction register
ifid_pc_plus1  output  32  IF/ID register holding PC+1 of the latched instruction
ifid_valid  output  1  IF/ID holds a real instruction
halted  output  1  FSM is in HALT
fetch_count  output  32  number of instructions latched with valid=1

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - PC=RESET_ADDR; ifid_instruction=0 (NOP); ifid_pc_plus1=0; ifid_valid=0; halted=0; fetch_count=0; FSM=RUN.
- ReadAddress = {zeros, PC[ADDR_BITS-1:0]}, combinational from the PC register. The instruction is latched on the same clock edge that advances the PC, so fetch latency is one cycle.
- pc_plus1 = (PC+1) mod 2**ADDR_BITS. The last word wraps to address 0.
- Jump target = {pc_plus1[31:26], jump_index}, reduced mod 2**ADDR_BITS. Branch target is also reduced mod 2**ADDR_BITS.
- FSM states: RUN and HALT. Per-edge priority in RUN:
  1. branch_taken: PC<=branch_target; ifid<=NOP, ifid_valid<=0. Overrides stall and jump.
  2. jump: PC<=jump target; ifid<=NOP, ifid_valid<=0. Overrides stall.
  3. stall: PC, ifid_* and fetch_count all hold.
  4. Otherwise:
     - PC<=pc_plus1; ifid_instruction<=instruction; ifid_pc_plus1<=pc_plus1; ifid_valid<=1; fetch_count+=1.
     - If instruction==HALT_INSTR, the word is still latched (valid, counted) and FSM<=HALT.
- HALT state:
  - PC holds. On the first HALT edge ifid_valid<=0 and ifid_instruction<=NOP, so the halt word spends exactly one cycle in IF/ID. fetch_count holds. halted=1.
  - jump and stall are ignored.
  - branch_taken: PC<=branch_target, FSM<=RUN, ifid stays NOP/invalid for that edge. This covers an older branch that resolves after the halt word was fetched speculatively.
  - HALT is left only by branch_taken or reset.
- fetch_count wraps at 2**32.
- All outputs are registered except ReadAddress.

Test Plan:
- Reset then free-run with memory word k = k+0x100, RESET_ADDR=0 -> ReadAddress 0,1,2,3 on successive cycles; ifid_instruction 0x100,0x101,0x102 one cycle behind; ifid_pc_plus1 1,2,3; fetch_count=3 after 3 edges.
- stall high for 2 cycles at PC=5 -> ReadAddress stays 5, ifid and fetch_count frozen; PC=6 on the first edge after stall drops.
- At PC=4, branch_taken=1 and jump=1 with branch_target=0x20, jump_index=0x10, stall=1 -> next PC=0x20, ifid_valid=0, ifid_instruction=0. Separately, jump alone at PC=4 -> PC=0x10 (upper bits from pc_plus1=5 are 0).
- ADDR_BITS=8, PC=255, no stall -> ReadAddress=0 next cycle, ifid_pc_plus1=0.
- Memory word 3 = 32'hFFFFFFFF -> halt word latched with ifid_valid=1, halted=1 next edge; the following cycle ifid_valid=0 and ReadAddress stays 4 indefinitely. Then branch_taken with target 2 -> halted=0, ReadAddress=2.
- Assert reset asynchronously mid-cycle while PC=7 and ifid_valid=1 -> all outputs return to reset values immediately, before the next clock edge; fetch resumes from RESET_ADDR after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS instruction-fetch stage with PC, IF/ID register and RUN/HALT control
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   stall                  : hold PC and IF/ID
//   branch_taken/_target   : EX-stage redirect, highest priority, also exits HALT
//   jump/jump_index        : ID-stage j/jal redirect
//   instruction            : combinational instruction-memory read data
//   ReadAddress            : word address to instruction memory (the PC)
//   ifid_instruction/_pc_plus1/_valid : IF/ID pipeline register
//   halted, fetch_count    : HALT state flag, count of valid latched instructions
module pc_fetch_unit #(
  parameter int          ADDR_BITS  = 8,
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instruction,
  output logic [31:0] ReadAddress,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d, pc_plus1;
  logic [31:0] pc_plus1_w, jump_target;
  logic [31:0] instr_q, instr_d, pcp1_q, pcp1_d, count_q, count_d;
  logic valid_q, valid_d;
  assign pc_plus1    = pc_q + 1'b1;
  assign pc_plus1_w  = 32'(pc_plus1);
  assign jump_target = {pc_plus1_w[31:26], jump_index};
  assign ReadAddress = 32'(pc_q);
  assign ifid_instruction = instr_q;
  assign ifid_pc_plus1    = pcp1_q;
  assign ifid_valid       = valid_q;
  assign halted           = state_q == HALT;
  assign fetch_count      = count_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    count_d = count_q;
    if (branch_taken) begin
      state_d = RUN;
      pc_d    = branch_target[ADDR_BITS-1:0];
      instr_d = '0;
      valid_d = 1'b0;
    end else if (state_q == HALT) begin
      // halt word leaves IF/ID after one cycle; PC frozen
      instr_d = '0;
      valid_d = 1'b0;
    end else if (jump) begin
      pc_d    = jump_target[ADDR_BITS-1:0];
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus1;
      instr_d = instruction;
      pcp1_d  = pc_plus1_w;
      valid_d = 1'b1;
      count_d = count_q + 1'b1;
      state_d = instruction == HALT_INSTR ? HALT : RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR[ADDR_BITS-1:0];
      instr_q <= '0;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end
endmodule
